// File: rtl/ksa_pkg.sv
// Shared state encoding, constants and byte helpers for the AES-128 key schedule sequencer.
// inv_mix_word is only referenced when KSA_INV_KEY_EN is defined.
package ksa_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRESENT = 3'd1,
      ST_SUB     = 3'd2,
      ST_EXPAND  = 3'd3,
      ST_INVMIX  = 3'd4
   } ksa_state_e;

   localparam int unsigned NUM_ROUNDS = 10;
   localparam logic [7:0]  RCON_INIT  = 8'h01;
   localparam logic [7:0]  RCON_POLY  = 8'h1b;

   function automatic bit sbox_lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4);
   endfunction

   // Forward AES S-box, entry 0 in the top byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_lut(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] a, x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a     = w[8*(3-i) +: 8];
         x2    = xtime(a);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a;
         mb[i] = x8 ^ x2 ^ a;
         md[i] = x8 ^ x4 ^ a;
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

endpackage

// File: rtl/ksa_key_sched_ctrl_if.sv
// Key-load and round-key handshake bundle for ksa_key_sched_ctrl.
// inv_mode is present only when KSA_INV_KEY_EN is defined.
interface ksa_key_sched_ctrl_if;
   logic         start;
   logic [127:0] key_in;
`ifdef KSA_INV_KEY_EN
   logic         inv_mode;
`endif
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;
   logic         done;

`ifdef KSA_INV_KEY_EN
   modport master (output start, key_in, inv_mode, rk_ready,
                   input  busy, rk_valid, rk_out, rk_idx, done);
   modport slave  (input  start, key_in, inv_mode, rk_ready,
                   output busy, rk_valid, rk_out, rk_idx, done);
`else
   modport master (output start, key_in, rk_ready,
                   input  busy, rk_valid, rk_out, rk_idx, done);
   modport slave  (input  start, key_in, rk_ready,
                   output busy, rk_valid, rk_out, rk_idx, done);
`endif
endinterface

// File: rtl/ksa_subword_serial.sv
// SubWord(RotWord(w3)) over SBOX_LANES sboxes, SBOX_LANES bytes per enabled cycle.
// o_last flags the cycle that writes the final byte group into the temp word.
module ksa_subword_serial
   import ksa_pkg::*;
#(
   parameter int SBOX_LANES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic [31:0] i_word,
   output logic [31:0] o_temp,
   output logic        o_last
);
   localparam int         SUB_CYC  = 4 / SBOX_LANES;
   localparam logic [1:0] LAST_CNT = 2'(SUB_CYC - 1);

   logic [1:0]  r_byte_cnt;
   logic [31:0] r_temp;
   logic [31:0] w_rot;
   logic [1:0]  w_pos [SBOX_LANES];
   logic [7:0]  w_in  [SBOX_LANES];
   logic [7:0]  w_out [SBOX_LANES];

   assign w_rot = {i_word[23:0], i_word[31:24]};

   // Lane l handles rotated byte position cnt*SBOX_LANES + l (position 0 = top byte).
   for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
      assign w_pos[l] = 2'(int'(r_byte_cnt) * SBOX_LANES + l);
      assign w_in[l]  = w_rot[{~w_pos[l], 3'b000} +: 8];
      assign w_out[l] = sbox_lut(w_in[l]);
   end

   assign o_last = (r_byte_cnt == LAST_CNT);
   assign o_temp = r_temp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte_cnt <= 2'd0;
         r_temp     <= '0;
      end else if (i_en) begin
         for (int l = 0; l < SBOX_LANES; l++) begin
            r_temp[{~w_pos[l], 3'b000} +: 8] <= w_out[l];
         end
         r_byte_cnt <= o_last ? 2'd0 : r_byte_cnt + 2'd1;
      end
   end

endmodule

// File: rtl/ksa_key_sched_ctrl.sv
// AES-128 key schedule sequencer: expands key_in into round keys 0..10 over valid/ready.
// Optional KSA_INV_KEY_EN adds inv_mode and an INVMIX state for equivalent-inverse-cipher keys.
//
//   state   | meaning
//   IDLE    | waiting for start; key register holds last expansion
//   PRESENT | round key r_idx on rk_out, rk_valid high until accepted
//   SUB     | SubWord(RotWord(w3)) running through the sbox lanes
//   EXPAND  | rcon fold, word XOR chain, rk_idx and rcon advance
//   INVMIX  | InvMixColumns copy of keys 1..9 (KSA_INV_KEY_EN only)
module ksa_key_sched_ctrl
   import ksa_pkg::*;
#(
   parameter int SBOX_LANES = 1
) (
   input logic                 clk,
   input logic                 rst,
   ksa_key_sched_ctrl_if.slave bus
);
   if (!sbox_lanes_legal(SBOX_LANES)) begin : g_bad_lanes
      $error("ksa_key_sched_ctrl: SBOX_LANES must be 1, 2 or 4");
   end

   ksa_state_e   r_state;
   ksa_state_e   w_state_nxt;
   logic [127:0] r_key;
   logic [7:0]   r_rcon;
   logic [3:0]   r_idx;
   logic         r_done;

   logic         w_hs;
   logic         w_last_key;
   logic         w_sub_en;
   logic         w_sub_last;
   logic [31:0]  w_temp;
   logic [31:0]  w_t;
   logic [31:0]  w_n0, w_n1, w_n2, w_n3;
   logic [127:0] w_key_nxt;

   assign w_hs       = (r_state == ST_PRESENT) && bus.rk_ready;
   assign w_last_key = (r_idx == 4'(NUM_ROUNDS));

   ksa_subword_serial #(
      .SBOX_LANES(SBOX_LANES)
   ) u_subword (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_sub_en),
      .i_word (r_key[31:0]),
      .o_temp (w_temp),
      .o_last (w_sub_last)
   );

   assign w_t       = w_temp ^ {r_rcon, 24'h000000};
   assign w_n0      = r_key[127:96] ^ w_t;
   assign w_n1      = r_key[95:64]  ^ w_n0;
   assign w_n2      = r_key[63:32]  ^ w_n1;
   assign w_n3      = r_key[31:0]   ^ w_n2;
   assign w_key_nxt = {w_n0, w_n1, w_n2, w_n3};

`ifdef KSA_INV_KEY_EN
   logic         r_inv;
   logic [127:0] r_inv_key;
   logic [127:0] w_inv_key;
   logic         w_goto_inv;
   logic         w_use_inv;

   for (genvar c = 0; c < 4; c++) begin : g_invmix
      assign w_inv_key[32*c +: 32] = inv_mix_word(r_key[32*c +: 32]);
   end

   // Transformed copy lives in its own register so r_key keeps the forward schedule.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inv     <= 1'b0;
         r_inv_key <= '0;
      end else begin
         if ((r_state == ST_IDLE) && bus.start) r_inv <= bus.inv_mode;
         if (r_state == ST_INVMIX) r_inv_key <= w_inv_key;
      end
   end

   // Evaluated in EXPAND, so r_idx is still the old index; key 10 skips INVMIX.
   assign w_goto_inv = r_inv && (r_idx != 4'(NUM_ROUNDS - 1));
   assign w_use_inv  = r_inv && (r_idx != 4'd0) && (r_idx != 4'(NUM_ROUNDS));
   assign bus.rk_out = w_use_inv ? r_inv_key : r_key;
`else
   assign bus.rk_out = r_key;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (bus.start) w_state_nxt = ST_PRESENT;
         ST_PRESENT: if (w_hs) w_state_nxt = w_last_key ? ST_IDLE : ST_SUB;
         ST_SUB:     if (w_sub_last) w_state_nxt = ST_EXPAND;
`ifdef KSA_INV_KEY_EN
         ST_EXPAND:  w_state_nxt = w_goto_inv ? ST_INVMIX : ST_PRESENT;
         ST_INVMIX:  w_state_nxt = ST_PRESENT;
`else
         ST_EXPAND:  w_state_nxt = ST_PRESENT;
`endif
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy     = (r_state != ST_IDLE);
      bus.rk_valid = (r_state == ST_PRESENT);
      w_sub_en     = (r_state == ST_SUB);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_key  <= '0;
         r_rcon <= RCON_INIT;
         r_idx  <= 4'd0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_key  <= bus.key_in;
                  r_idx  <= 4'd0;
                  r_rcon <= RCON_INIT;
               end
            end
            ST_PRESENT: begin
               if (w_hs && w_last_key) r_done <= 1'b1;
            end
            ST_EXPAND: begin
               r_key  <= w_key_nxt;
               r_idx  <= r_idx + 4'd1;
               r_rcon <= xtime(r_rcon);
            end
            default: ;
         endcase
      end
   end

   assign bus.rk_idx = r_idx;
   assign bus.done   = r_done;

endmodule

// File: tb/tb_ksa_key_sched_ctrl.sv
// Directed scoreboard bench for ksa_key_sched_ctrl with 1, 2 and 4 sbox lanes on one clock.
// Golden round keys come from an independent model (computed S-box, GF(2^8) multiply).
module tb_ksa_key_sched_ctrl;

   typedef struct packed {
      logic [3:0]   idx;
      logic [127:0] key;
   } sb_t;

   localparam logic [127:0] K_FIPS     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K_FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K_FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K_SEQ      = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K_SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ksa_key_sched_ctrl_if bus1 ();
   ksa_key_sched_ctrl_if bus2 ();
   ksa_key_sched_ctrl_if bus4 ();

   ksa_key_sched_ctrl #(.SBOX_LANES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   ksa_key_sched_ctrl #(.SBOX_LANES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
   ksa_key_sched_ctrl #(.SBOX_LANES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

   virtual ksa_key_sched_ctrl_if vif;

   int           n_assert = 0;
   int           n_fail   = 0;
   logic [7:0]   sbox_m   [256];
   logic [127:0] model_rk [11];
   sb_t          sb_q     [$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] b;
      b = 8'h00;
      for (int c = 1; c < 256; c++) begin
         if (gmul(x, 8'(c)) == 8'h01) b = 8'(c);
      end
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] inv_mix(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

   task automatic build_model(input logic [127:0] key, input bit inv);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) begin
         if (inv && r > 0 && r < 10)
            model_rk[r] = {inv_mix(w[4*r]), inv_mix(w[4*r+1]), inv_mix(w[4*r+2]), inv_mix(w[4*r+3])};
         else
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   // Starts an expansion on DUT d and consumes all keys; optional 20-cycle stall
   // at hold_idx, or a start pulse followed by a reset at abort_idx.
   task automatic run_keys(input int d, input logic [127:0] key, input bit inv,
                           input int sub_cyc, input int hold_idx, input int abort_idx);
      int  c;
      int  lat;
      sb_t e;
      case (d)
         1:       vif = bus1;
         2:       vif = bus2;
         default: vif = bus4;
      endcase
      build_model(key, inv);
      for (int r = 0; r < 11; r++) sb_q.push_back(sb_t'{4'(r), model_rk[r]});
      vif.key_in   = key;
`ifdef KSA_INV_KEY_EN
      vif.inv_mode = inv;
`endif
      vif.rk_ready = 1'b1;
      vif.start    = 1'b1;
      tick();
      vif.start    = 1'b0;
      for (int n = 0; n <= 10; n++) begin
         c = 0;
         while (!vif.rk_valid && c < 40) begin
            tick();
            c++;
         end
         chk("rk_valid_wait", 128'(vif.rk_valid), 128'd1);
         if (!vif.rk_valid) begin
            sb_q.delete();
            return;
         end
         lat = (n == 0) ? 1 : sub_cyc + 2 + ((inv && n <= 9) ? 1 : 0);
         chk("latency", 128'(c + 1), 128'(lat));
         e = sb_q.pop_front();
         chk("rk_idx", 128'(vif.rk_idx), 128'(e.idx));
         chk("rk_out", vif.rk_out, e.key);
         chk("busy_high", 128'(vif.busy), 128'd1);
         if (key == K_FIPS && !inv && n == 1) chk("fips_r1", vif.rk_out, K_FIPS_R1);
         if (key == K_FIPS && n == 10) chk("fips_r10", vif.rk_out, K_FIPS_R10);
         if (key == K_SEQ && n == 10) chk("seq_r10", vif.rk_out, K_SEQ_R10);
         if (n == hold_idx) begin
            vif.rk_ready = 1'b0;
            repeat (20) begin
               tick();
               chk("hold_valid", 128'(vif.rk_valid), 128'd1);
               chk("hold_idx", 128'(vif.rk_idx), 128'(e.idx));
               chk("hold_out", vif.rk_out, e.key);
            end
            vif.rk_ready = 1'b1;
         end
         if (n == abort_idx) begin
            vif.rk_ready = 1'b0;
            vif.start    = 1'b1;
            vif.key_in   = ~key;
            tick();
            vif.start    = 1'b0;
            chk("busy_start_idx", 128'(vif.rk_idx), 128'(e.idx));
            chk("busy_start_out", vif.rk_out, e.key);
            chk("busy_start_valid", 128'(vif.rk_valid), 128'd1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("abort_valid", 128'(vif.rk_valid), 128'd0);
            chk("abort_busy", 128'(vif.busy), 128'd0);
            chk("abort_idx", 128'(vif.rk_idx), 128'd0);
            chk("abort_out", vif.rk_out, 128'd0);
            chk("abort_done", 128'(vif.done), 128'd0);
            sb_q.delete();
            vif.rk_ready = 1'b1;
            return;
         end
         tick();
         if (n == 10) begin
            chk("done_pulse", 128'(vif.done), 128'd1);
            chk("busy_fall", 128'(vif.busy), 128'd0);
            tick();
            chk("done_once", 128'(vif.done), 128'd0);
         end else begin
            chk("valid_drop", 128'(vif.rk_valid), 128'd0);
         end
      end
      chk("sb_empty", 128'(sb_q.size()), 128'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus1.start = 1'b0; bus1.key_in = '0; bus1.rk_ready = 1'b0;
      bus2.start = 1'b0; bus2.key_in = '0; bus2.rk_ready = 1'b0;
      bus4.start = 1'b0; bus4.key_in = '0; bus4.rk_ready = 1'b0;
`ifdef KSA_INV_KEY_EN
      bus1.inv_mode = 1'b0; bus2.inv_mode = 1'b0; bus4.inv_mode = 1'b0;
`endif
      for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
      tick();
      tick();
      rst = 1'b0;
      chk("reset_valid", 128'(bus1.rk_valid), 128'd0);
      chk("reset_busy", 128'(bus1.busy), 128'd0);
      chk("reset_idx", 128'(bus1.rk_idx), 128'd0);
      chk("reset_out", bus1.rk_out, 128'd0);
      chk("reset_done", 128'(bus1.done), 128'd0);
      chk("reset_busy4", 128'(bus4.busy), 128'd0);

      run_keys(1, K_FIPS, 1'b0, 4, -1, -1);
      run_keys(2, K_FIPS, 1'b0, 2, -1, -1);
      run_keys(4, K_FIPS, 1'b0, 1, -1, -1);
      run_keys(1, K_FIPS, 1'b0, 4, 3, -1);
      run_keys(1, K_FIPS, 1'b0, 4, -1, 5);
      run_keys(1, K_FIPS, 1'b0, 4, -1, -1);
      run_keys(1, K_SEQ, 1'b0, 4, -1, -1);

      // Reset dominates a simultaneous start.
      bus1.key_in = K_SEQ;
      bus1.start  = 1'b1;
      rst         = 1'b1;
      tick();
      rst         = 1'b0;
      bus1.start  = 1'b0;
      chk("rst_wins_busy", 128'(bus1.busy), 128'd0);
      chk("rst_wins_valid", 128'(bus1.rk_valid), 128'd0);
      tick();
      chk("rst_wins_idle", 128'(bus1.busy), 128'd0);

      run_keys(2, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 2, 7, -1);
      run_keys(4, K_SEQ, 1'b0, 1, 0, -1);
`ifdef KSA_INV_KEY_EN
      run_keys(1, K_FIPS, 1'b1, 4, -1, -1);
      run_keys(4, K_SEQ, 1'b1, 1, 2, -1);
      run_keys(2, K_FIPS, 1'b0, 2, -1, -1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
